// File: rtl/fp_align_seq.sv
// Multi-cycle operand alignment for the FP adder front end: picks the larger
// operand, then right-shifts the smaller mantissa STEP bits per cycle with sticky.
module fp_align_seq #(
  parameter int STEP  = 4,
  parameter int MAXSH = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [36:0] NA,
  input  logic [36:0] NB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Comp,
  output logic        SA,
  output logic        SB,
  output logic [7:0]  EO,
  output logic [27:0] MA,
  output logic [27:0] MB,
  output logic        busy
);

  // state     | meaning
  // S_IDLE    | waiting for an operand pair, in_ready high
  // S_COMPARE | select larger operand, load shifter and shift count
  // S_SHIFT   | shift smaller mantissa by up to STEP per cycle
  // S_DONE    | aligned pair presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [36:0] r_na;
  logic [36:0] r_nb;
  logic        r_comp;
  logic        r_sa;
  logic        r_sb;
  logic [7:0]  r_eo;
  logic [27:0] r_ma;
  logic [27:0] r_sh;
  logic        r_sticky;
  logic [8:0]  r_rem;

  logic        w_comp;
  logic [8:0]  w_diff;
  logic [8:0]  w_rem0;
  logic [8:0]  w_amt;
  logic [27:0] w_out_mask;

  // Ties on exponent and mantissa keep A as the larger operand.
  assign w_comp = (r_nb[35:28] > r_na[35:28]) ||
                  ((r_nb[35:28] == r_na[35:28]) && (r_nb[27:0] > r_na[27:0]));
  assign w_diff = w_comp ? ({1'b0, r_nb[35:28]} - {1'b0, r_na[35:28]})
                         : ({1'b0, r_na[35:28]} - {1'b0, r_nb[35:28]});
  assign w_rem0 = (w_diff >= 9'(MAXSH)) ? 9'(MAXSH) : w_diff;

  assign w_amt      = (r_rem < 9'(STEP)) ? r_rem : 9'(STEP);
  assign w_out_mask = (28'd1 << w_amt) - 28'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = S_COMPARE;
      end
      S_COMPARE: w_next = (w_rem0 != 9'd0) ? S_SHIFT : S_DONE;
      S_SHIFT:   if (r_rem == w_amt) w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_na     <= '0;
      r_nb     <= '0;
      r_comp   <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_eo     <= '0;
      r_ma     <= '0;
      r_sh     <= '0;
      r_sticky <= 1'b0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_na <= NA;
            r_nb <= NB;
          end
        end
        S_COMPARE: begin
          r_comp   <= w_comp;
          r_sa     <= w_comp ? r_nb[36]    : r_na[36];
          r_eo     <= w_comp ? r_nb[35:28] : r_na[35:28];
          r_ma     <= w_comp ? r_nb[27:0]  : r_na[27:0];
          r_sb     <= w_comp ? r_na[36]    : r_nb[36];
          r_sh     <= w_comp ? r_na[27:0]  : r_nb[27:0];
          r_sticky <= 1'b0;
          r_rem    <= w_rem0;
        end
        S_SHIFT: begin
          r_sh     <= r_sh >> w_amt;
          r_sticky <= r_sticky | (|(r_sh & w_out_mask));
          r_rem    <= r_rem - w_amt;
        end
        default: ;
      endcase
    end
  end

  assign Comp = r_comp;
  assign SA   = r_sa;
  assign SB   = r_sb;
  assign EO   = r_eo;
  assign MA   = r_ma;
  assign MB   = {r_sh[27:1], r_sh[0] | r_sticky};

endmodule

// File: tb/tb_fp_align_seq.sv
// Directed bench for fp_align_seq: alignment, sticky, saturation, backpressure
// and asynchronous reset during a shift.
module tb_fp_align_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] NA;
  logic [36:0] NB;
  logic        out_valid;
  logic        out_ready;
  logic        Comp;
  logic        SA;
  logic        SB;
  logic [7:0]  EO;
  logic [27:0] MA;
  logic [27:0] MB;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  fp_align_seq #(.STEP(4), .MAXSH(28)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .NA(NA), .NB(NB), .out_valid(out_valid), .out_ready(out_ready),
    .Comp(Comp), .SA(SA), .SB(SB), .EO(EO), .MA(MA), .MB(MB), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_op(input logic [36:0] a, input logic [36:0] b);
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      tick();
      g++;
    end
    check("in_ready_before_op", in_ready, 1);
    in_valid = 1'b1;
    NA = a;
    NB = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    check(tag, c, exp_lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    NA        = '0;
    NB        = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_comp", Comp, 0);
    check("rst_eo", EO, 0);
    check("rst_ma", MA, 0);
    check("rst_mb", MB, 0);
    rst_n = 1'b1;
    tick();

    // Align by 3, one SHIFT cycle
    start_op({1'b0, 8'h80, 28'h8000000}, {1'b1, 8'h7D, 28'h8000000});
    check("a3_busy_compare", busy, 1);
    wait_done("a3_latency", 2);
    check("a3_comp", Comp, 0);
    check("a3_sa", SA, 0);
    check("a3_sb", SB, 1);
    check("a3_eo", EO, 8'h80);
    check("a3_ma", MA, 28'h8000000);
    check("a3_mb", MB, 28'h1000000);
    check("a3_in_ready_done", in_ready, 0);
    release_out();

    // Equal exponents, B mantissa larger
    start_op({1'b0, 8'h81, 28'h8000000}, {1'b0, 8'h81, 28'hC000000});
    wait_done("eq_latency", 1);
    check("eq_comp", Comp, 1);
    check("eq_eo", EO, 8'h81);
    check("eq_ma", MA, 28'hC000000);
    check("eq_mb", MB, 28'h8000000);
    release_out();

    // Full tie keeps A as larger
    start_op({1'b1, 8'h42, 28'h1234567}, {1'b0, 8'h42, 28'h1234567});
    wait_done("tie_latency", 1);
    check("tie_comp", Comp, 0);
    check("tie_sa", SA, 1);
    check("tie_sb", SB, 0);
    check("tie_mb", MB, 28'h1234567);
    release_out();

    // Sticky collection, shift 5
    start_op({1'b0, 8'h90, 28'h8000000}, {1'b0, 8'h8B, 28'h000001F});
    wait_done("stk_latency", 3);
    check("stk_comp", Comp, 0);
    check("stk_mb", MB, 28'h0000001);
    release_out();

    // Saturation, diff 40 clipped to 28, then backpressure
    start_op({1'b0, 8'h10, 28'h4000000}, {1'b0, 8'h38, 28'h8000000});
    wait_done("sat_latency", 8);
    check("sat_comp", Comp, 1);
    check("sat_eo", EO, 8'h38);
    check("sat_ma", MA, 28'h8000000);
    check("sat_mb", MB, 28'h0000001);
    in_valid = 1'b1;
    NA = {1'b1, 8'hFF, 28'hFFFFFFF};
    NB = {1'b1, 8'h01, 28'h0000003};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_eo", EO, 8'h38);
      check("bp_mb", MB, 28'h0000001);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_turn_out_valid", out_valid, 0);
    check("bp_turn_in_ready", in_ready, 1);
    check("bp_turn_busy", busy, 0);
    tick();
    check("bp_not_captured", busy, 0);

    // Reset during the second SHIFT cycle
    start_op({1'b0, 8'h10, 28'h4000000}, {1'b0, 8'h38, 28'h8000000});
    tick();
    tick();
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_comp", Comp, 0);
    check("mid_rst_eo", EO, 0);
    check("mid_rst_ma", MA, 0);
    check("mid_rst_mb", MB, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_op({1'b0, 8'h80, 28'h8000000}, {1'b1, 8'h7D, 28'h8000000});
    wait_done("post_latency", 2);
    check("post_eo", EO, 8'h80);
    check("post_mb", MB, 28'h1000000);
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_align_seq.md
Name: fp_align_seq

Overview:
- Multi-cycle operand-alignment sequencer for the FP adder front end.
- Accepts two 37-bit operands under a valid/ready handshake and selects the larger-magnitude operand.
- Right-shifts the smaller mantissa by the exponent difference, at most STEP bits per cycle, and collects a sticky bit.
- Presents the aligned pair to the mantissa add stage under a valid/ready handshake. Replaces the single-cycle barrel shift where area matters more than latency.

Parameters:
- STEP, 4, maximum right-shift positions applied per SHIFT cycle; legal range 1..28.
- MAXSH, 28, saturation limit for the alignment shift; equals the mantissa width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair is valid.
- in_ready  out  1  block can accept an operand pair.
- NA  in  37  operand A: [36] sign, [35:28] exponent, [27:0] mantissa.
- NB  in  37  operand B, same format as NA.
- out_valid  out  1  aligned result is valid.
- out_ready  in  1  downstream accepts the result.
- Comp  out  1  1 when operand B was selected as the larger operand.
- SA  out  1  sign of the larger operand.
- SB  out  1  sign of the smaller operand.
- EO  out  8  exponent of the larger operand.
- MA  out  28  mantissa of the larger operand, unshifted.
- MB  out  28  aligned mantissa of the smaller operand, with sticky in bit 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE, COMPARE, SHIFT, DONE.
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - Comp, SA, SB, EO, MA, MB and all internal registers cleared to 0.
  - An operation in flight is discarded with no partial result.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, NA and NB are registered and state goes to COMPARE. Call this edge k.
- COMPARE (one cycle, edge k+1):
  - Comp=1 iff EB>EA, or (EB==EA and mantB>mantA). Ties on both exponent and mantissa give Comp=0.
  - Load EO/MA/SA from the selected larger operand, and SB plus the shift register from the other operand.
  - Clear sticky.
  - remaining = min(|EA-EB|, MAXSH), computed on 9-bit unsigned arithmetic without wrap.
  - Go to SHIFT if remaining>0, otherwise go to DONE.
- SHIFT (one edge per step):
  - amt = min(remaining, STEP).
  - Shift the register right by amt with zero fill.
  - sticky |= OR of the amt bits shifted out.
  - remaining -= amt.
  - When remaining reaches 0, go to DONE.
  - Number of SHIFT cycles N = ceil(remaining0/STEP).
- DONE:
  - out_valid=1.
  - MB = shifted value with bit 0 ORed with sticky.
  - All outputs are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE: out_valid drops and in_ready rises the next cycle.
- Latency: out_valid is first high in the cycle after edge k+1+N.
  - Minimum latency is 2 cycles (N=0).
  - Maximum latency with STEP=4 is 9 cycles (N=7).
- Throughput: one operation in flight; in_ready=0 from COMPARE through DONE.
  - in_valid outside IDLE is ignored. The upstream must hold its data until it sees in_ready.
- Saturation: |EA-EB| >= 28 shifts out the whole mantissa. MB = 0x0000001 if the smaller mantissa was nonzero, otherwise 0.
- No special handling of zero, Inf or NaN encodings; exponent fields are treated as plain unsigned values.
- Simultaneous events:
  - out_ready=1 in DONE and in_valid=1 on the same edge: only the DONE to IDLE transition is taken. The new operand is accepted on a later edge in IDLE, so there is no same-cycle turnaround.
  - rst_n assertion overrides everything in every state.

Test Plan:
- Align by 3, STEP=4: NA={0,0x80,0x8000000}, NB={1,0x7D,0x8000000} -> N=1; out_valid after edge k+2; Comp=0, SA=0, SB=1, EO=0x80, MA=0x8000000, MB=0x1000000.
- Equal exponents: NA={0,0x81,0x8000000}, NB={0,0x81,0xC000000} -> N=0; out_valid after edge k+1; Comp=1, EO=0x81, MA=0xC000000, MB=0x8000000.
- Sticky: NA={0,0x90,0x8000000}, NB={0,0x8B,0x000001F} -> shift 5 (N=2); MB=0x0000001, Comp=0.
- Saturation: EA=0x10, EB=0x38, mantA=0x4000000, mantB=0x8000000 -> diff 40 clipped to 28, N=7; Comp=1, EO=0x38, MA=0x8000000, MB=0x0000001; out_valid after edge k+8.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, second operand not captured; after out_ready=1, IDLE the next cycle and in_ready=1.
- Reset mid-SHIFT: drop rst_n during the 2nd SHIFT cycle of the saturation case -> outputs 0 and in_ready=1 immediately (asynchronous); after release, a new operand completes normally.
